// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per clock, with start/busy/done handshake.
// Optional build macro: MULDIV_FAST_SPECIAL_EN (divide-by-zero, signed
// overflow and multiply-by-zero finish one cycle after acceptance).
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mdStart,
    input  logic            mdFlush,
    input  logic [2:0]      mdControl,
    input  logic [XLEN-1:0] mdIn1,
    input  logic [XLEN-1:0] mdIn2,
    output logic [XLEN-1:0] mdOut,
    output logic            mdBusy,
    output logic            mdDone
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        ctl_q;
    logic [AW-1:0]     acc_q;      // mul: {partial high, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]   b_q;        // mul: multiplicand magnitude; div: divisor magnitude
    logic              neg_res_q;  // negate product / quotient at the end
    logic              neg_rem_q;  // negate remainder at the end
    logic              div0_q;
    logic [XLEN-1:0]   out_q;
    logic              busy_q;
    logic              done_q;

    // Accept-time operand preparation
    logic              is_div, a_sgn, b_sgn, neg_a, neg_b, div0, start_ok;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [AW-1:0]     acc_init;
    logic [XLEN-1:0]   b_init;
    logic              neg_res_init;

    // Decode signedness, form magnitudes and the initial datapath contents
    always_comb begin
        is_div       = mdControl[2];
        a_sgn        = is_div ? ~mdControl[0] : (mdControl[1:0] != 2'b11);
        b_sgn        = is_div ? ~mdControl[0] : ~mdControl[1];
        neg_a        = a_sgn & mdIn1[XLEN-1];
        neg_b        = b_sgn & mdIn2[XLEN-1];
        a_mag        = neg_a ? -mdIn1 : mdIn1;
        b_mag        = neg_b ? -mdIn2 : mdIn2;
        div0         = is_div & (mdIn2 == '0);
        start_ok     = mdStart & ~mdFlush & (state_q != CALC);
        acc_init     = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
        b_init       = is_div ? b_mag : a_mag;
        neg_res_init = (neg_a ^ neg_b) & ~div0;
    end

`ifdef MULDIV_FAST_SPECIAL_EN
    logic              special;
    logic [XLEN-1:0]   special_res;

    // Results that are known without iterating
    always_comb begin
        logic ovf, mul0;
        ovf  = is_div & ~mdControl[0] & (mdIn1 == {1'b1, {(XLEN-1){1'b0}}}) & (mdIn2 == '1);
        mul0 = ~is_div & ((mdIn1 == '0) | (mdIn2 == '0));
        special     = div0 | ovf | mul0;
        special_res = '0;
        if (div0)
            special_res = mdControl[1] ? mdIn1 : '1;
        else if (ovf)
            special_res = mdControl[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`endif

    // One iteration step plus the sign-fixed result of that step
    logic [XLEN:0]     mul_sum;
    logic [AW-1:0]     mul_d, div_d, acc_d, prod_fix;
    logic [XLEN:0]     rem_sh;
    logic              ge;
    logic [XLEN-1:0]   rem_new, quo_fix, rem_fix, result;

    // Shift-add / restoring-divide step and final sign correction
    always_comb begin
        mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_d    = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
        ge       = rem_sh >= {1'b0, b_q};
        rem_new  = ge ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0];
        div_d    = {rem_new, acc_q[XLEN-2:0], ge};
        acc_d    = ctl_q[2] ? div_d : mul_d;
        prod_fix = neg_res_q ? -acc_d : acc_d;
        quo_fix  = div0_q ? '1 : (neg_res_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0]);
        rem_fix  = neg_rem_q ? -acc_d[AW-1:XLEN] : acc_d[AW-1:XLEN];
        case (ctl_q)
            3'b000:                 result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[AW-1:XLEN];
            3'b100, 3'b101:         result = quo_fix;
            default:                result = rem_fix;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ctl_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start_ok) begin
                        ctl_q     <= mdControl;
                        acc_q     <= acc_init;
                        b_q       <= b_init;
                        neg_res_q <= neg_res_init;
                        neg_rem_q <= neg_a;
                        div0_q    <= div0;
                        cnt_q     <= '0;
`ifdef MULDIV_FAST_SPECIAL_EN
                        if (special) begin
                            state_q <= DONE;
                            out_q   <= special_res;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else
`endif
                        begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (mdFlush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(XLEN - 1)) begin
                            state_q <= DONE;
                            out_q   <= result;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mdOut  = out_q;
    assign mdBusy = busy_q;
    assign mdDone = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed RV32M ops checked
// against an arithmetic reference model, including result latency.
module tb_muldiv_unit;

    localparam logic [31:0] MINV = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mdStart = 1'b0;
    logic        mdFlush = 1'b0;
    logic [2:0]  mdControl = 3'b000;
    logic [31:0] mdIn1 = '0;
    logic [31:0] mdIn2 = '0;
    logic [31:0] mdOut;
    logic        mdBusy;
    logic        mdDone;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .mdStart(mdStart), .mdFlush(mdFlush),
        .mdControl(mdControl), .mdIn1(mdIn1), .mdIn2(mdIn2),
        .mdOut(mdOut), .mdBusy(mdBusy), .mdDone(mdDone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MINV && b == ONES) return MINV;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == ONES) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c[2]) return (b == 0) || (!c[0] && a == MINV && b == ONES);
        return (a == 0) || (b == 0);
    endfunction

    function automatic int latency(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_SPECIAL_EN
        if (is_special(c, a, b)) return 1;
`else
        if (is_special(c, a, b)) return 33;
`endif
        return 33;
    endfunction

    // Wait for the unit to accept, issue one op, optionally expect its result
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit expect_done);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (mdBusy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("issue_wait_timeout", 32'(mdBusy), 32'h0);
        mdControl = c; mdIn1 = a; mdIn2 = b; mdStart = 1'b1;
        e.res = exp;
        e.done_cyc = cyc + latency(c, a, b);
        if (expect_done) sb_q.push_back(e);
        @(negedge clk);
        mdStart = 1'b0;
        check("busy_after_accept", 32'(mdBusy), 32'(latency(c, a, b) != 1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return ONES;
            3: return MINV;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every mdDone must match the oldest expectation, value and cycle
    always @(negedge clk) begin
        if (!reset && mdDone) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", mdOut, e.res);
                check("latency", 32'(cyc), 32'(e.done_cyc));
                last_res = e.res;
            end
        end
    end

    initial begin
        logic [2:0]  c;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        check("reset_out", mdOut, 32'h0);
        check("reset_busy", 32'(mdBusy), 32'h0);
        check("reset_done", 32'(mdDone), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        issue(3'd3, ONES, ONES, 32'hFFFF_FFFE, 1'b1);
        issue(3'd1, ONES, ONES, 32'h0000_0000, 1'b1);
        issue(3'd2, ONES, ONES, 32'hFFFF_FFFF, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
        issue(3'd7, 32'd100, 32'd7, 32'd2, 1'b1);
        issue(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1);
        issue(3'd7, 32'h1234, 32'd0, 32'h1234, 1'b1);
        issue(3'd4, MINV, ONES, MINV, 1'b1);
        issue(3'd6, MINV, ONES, 32'h0, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd0, ONES, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);
        issue(3'd0, 32'd0, 32'd5, 32'd0, 1'b1);
        wait_drain();

        // Start pulse during CALC is ignored
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        repeat (4) @(negedge clk);
        mdControl = 3'd5; mdIn1 = 32'd9; mdIn2 = 32'd3; mdStart = 1'b1;
        @(negedge clk);
        mdStart = 1'b0;
        wait_drain();

        // Flush at CALC cycle 10: busy drops, no done, result held
        issue(3'd5, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        mdFlush = 1'b1;
        @(negedge clk);
        mdFlush = 1'b0;
        check("flush_busy", 32'(mdBusy), 32'h0);
        check("flush_out_held", mdOut, last_res);
        repeat (40) @(negedge clk);

        // Flush together with start in IDLE: nothing accepted
        mdControl = 3'd0; mdIn1 = 32'd3; mdIn2 = 32'd3; mdStart = 1'b1; mdFlush = 1'b1;
        @(negedge clk);
        mdStart = 1'b0; mdFlush = 1'b0;
        check("flush_start_busy", 32'(mdBusy), 32'h0);
        repeat (40) @(negedge clk);

        // Reset at CALC cycle 20: outputs clear at once, next op correct
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_out", mdOut, 32'h0);
        check("rst_mid_busy", 32'(mdBusy), 32'h0);
        check("rst_mid_done", 32'(mdDone), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_drain();

        // Random ops, issued back to back
        for (int i = 0; i < 150; i++) begin
            c = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(c, a, b, ref_model(c, a, b), 1'b1);
        end
        wait_drain();
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
